sram_bus_arbiter: RTL

//  Shares one SRAM-like memory port between the IF-stage fetch requester and the EX/MEM data requester.

---
 rtl/sram_bus_arbiter_pkg.sv | 34 +++
 rtl/sram_bus_arbiter_if.sv | 29 ++
 rtl/sram_bus_arbiter_owner_fifo.sv | 85 ++++++++
 rtl/sram_bus_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter_pkg
// Shared definitions for the fetch/data SRAM-port arbiter:
//   - owner encodings written into the in-order response FIFO
//   - SRAM access size encodings
//   - arbiter FSM state encodings (plain localparams, not an enum)
//   - the address-phase field bundle routed from a requester to memory
// -----------------------------------------------------------------------------
package sram_bus_arbiter_pkg;

  // Owner tag stored per accepted transaction
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // Access size encodings carried on *_size
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Arbiter FSM states
  localparam logic [1:0] ARB_IDLE        = 2'd0;
  localparam logic [1:0] ARB_LOCKED_INST = 2'd1;
  localparam logic [1:0] ARB_LOCKED_DATA = 2'd2;

  // Everything that travels with an address phase
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter_if
// One SRAM-like port: request/address phase plus in-order response phase.
//   master : drives req/wr/size/wstrb/addr/wdata, receives addr_ok/data_ok/rdata
//   slave  : the opposite direction
// The arbiter is a slave to the fetch and data requesters and a master toward
// the downstream memory bridge.
// -----------------------------------------------------------------------------
interface sram_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// -----------------------------------------------------------------------------
// owner_fifo
// 1-bit wide, DEPTH-deep in-order FIFO that remembers which requester owns each
// accepted-but-unanswered transaction.
// Ports:
//   clk, resetn     clock and asynchronous active-low reset
//   push, push_owner enqueue an owner tag (ignored when full)
//   pop             dequeue the head (ignored when empty)
//   full, empty     status from the registered occupancy count
//   head            owner tag of the oldest entry
// -----------------------------------------------------------------------------
module owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_owner,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] slot_q, slot_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // Pointers wrap modulo DEPTH; DEPTH is a power of two but may be 1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = slot_q[rd_ptr_q];

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next-state bookkeeping: a push and a pop in the same cycle leave the
  // count unchanged while both pointers advance.
  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      slot_d[wr_ptr_q] = push_owner;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards any in-flight entries.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter
// Shares one SRAM-like memory port between the IF-stage fetch requester and the
// EX/MEM data requester. Data has fixed priority, with a starvation guard that
// forces fetch to win after STARVE_LIMIT consecutive data grants. Up to
// OUTSTANDING transactions may be in flight; responses come back in order and
// are steered to their owner through owner_fifo. Both phases are routed
// combinationally, adding no latency.
// Ports:
//   clk, resetn   clock and asynchronous active-low reset
//   inst_bus      fetch requester port (slave side)
//   data_bus      data requester port (slave side)
//   mem_bus       downstream memory bridge port (master side)
//   arb_err       sticky: a response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               resetn,
  sram_bus_arbiter_if.slave  inst_bus,
  sram_bus_arbiter_if.slave  data_bus,
  sram_bus_arbiter_if.master mem_bus,
  output logic               arb_err
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [1:0]      state_q, state_d;
  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
  logic            rst_done_q, rst_done_d;
  logic            arb_err_q, arb_err_d;

  logic            starved;
  logic            grant_data;
  logic            mem_req;
  logic            handshake;
  logic            fifo_full, fifo_empty, fifo_head;
  logic            pop;
  bus_req_t        inst_fields, data_fields, mem_fields;

  assign inst_fields = '{wr: inst_bus.wr, size: inst_bus.size, wstrb: inst_bus.wstrb,
                         addr: inst_bus.addr, wdata: inst_bus.wdata};
  assign data_fields = '{wr: data_bus.wr, size: data_bus.size, wstrb: data_bus.wstrb,
                         addr: data_bus.addr, wdata: data_bus.wdata};

  // Fetch is starved once data has won STARVE_LIMIT times in a row while
  // fetch was waiting.
  assign starved = inst_bus.req & (starve_cnt_q == SC_W'(STARVE_LIMIT));

  // Grant selection. A lock pins the grant on whoever was presented to the
  // memory but not yet accepted, so address/fields cannot switch mid-phase.
  always_comb begin
    grant_data = 1'b0;
    case (state_q)
      ARB_LOCKED_INST: grant_data = 1'b0;
      ARB_LOCKED_DATA: grant_data = 1'b1;
      default:         grant_data = data_bus.req & ~starved;
    endcase
  end

  // Full is judged on the registered count, so a same-cycle pop does not
  // re-open the port. rst_done holds everything quiet for the first cycle.
  assign mem_req   = rst_done_q & (inst_bus.req | data_bus.req) & ~fifo_full;
  assign handshake = mem_req & mem_bus.addr_ok;
  assign mem_fields = grant_data ? data_fields : inst_fields;

  assign mem_bus.req   = mem_req;
  assign mem_bus.wr    = mem_fields.wr;
  assign mem_bus.size  = mem_fields.size;
  assign mem_bus.wstrb = mem_fields.wstrb;
  assign mem_bus.addr  = mem_fields.addr;
  assign mem_bus.wdata = mem_fields.wdata;

  assign inst_bus.addr_ok = handshake & ~grant_data;
  assign data_bus.addr_ok = handshake & grant_data;

  // Responses: pop only when something is outstanding and steer data_ok by
  // the head owner tag. Read data is broadcast to both requesters.
  assign pop = rst_done_q & mem_bus.data_ok & ~fifo_empty;

  assign inst_bus.data_ok = pop & (fifo_head == OWNER_INST);
  assign data_bus.data_ok = pop & (fifo_head == OWNER_DATA);
  assign inst_bus.rdata   = mem_bus.rdata;
  assign data_bus.rdata   = mem_bus.rdata;

  assign arb_err = arb_err_q;

  owner_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_owner_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (handshake),
    .push_owner (grant_data ? OWNER_DATA : OWNER_INST),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

  // Lock FSM: a presented-but-refused request latches its owner; the
  // handshake releases the lock.
  always_comb begin
    state_d = state_q;
    if (handshake) begin
      state_d = ARB_IDLE;
    end else if (mem_req) begin
      state_d = grant_data ? ARB_LOCKED_DATA : ARB_LOCKED_INST;
    end
  end

  // Starvation counter: counts data handshakes while fetch waits, saturates
  // at the limit, and clears on a fetch handshake or when fetch is idle.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!inst_bus.req) begin
      starve_cnt_d = '0;
    end else if (handshake && !grant_data) begin
      starve_cnt_d = '0;
    end else if (handshake && grant_data && (starve_cnt_q != SC_W'(STARVE_LIMIT))) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
  end

  // rst_done rises one cycle after reset release; arb_err is sticky once a
  // response shows up with an empty owner FIFO.
  always_comb begin
    rst_done_d = 1'b1;
    arb_err_d  = arb_err_q | (mem_bus.data_ok & fifo_empty);
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ARB_IDLE;
      starve_cnt_q <= '0;
      rst_done_q   <= 1'b0;
      arb_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rst_done_q   <= rst_done_d;
      arb_err_q    <= arb_err_d;
    end
  end

endmodule
